// File: rtl/ext_mem_resp_module_if.sv
// mem_ext burst bus: request side driven by the master (PTW / refill), response by the memory.
interface ext_mem_resp_module_if #(
    parameter int PADDR_WIDTH = 34
);
    logic                   i_mem_ext_rden;
    logic                   i_mem_ext_wren;
    logic [15:0]            i_mem_ext_mask;
    logic [2:0]             i_mem_ext_burst;
    logic [PADDR_WIDTH-1:0] i_mem_ext_paddr;
    logic [127:0]           i_mem_ext_wdat;
    logic                   i_mem_ext_burst_start;
    logic                   i_mem_ext_burst_end;
    logic                   i_mem_ext_burst_vld;
    logic [127:0]           o_ext_mem_rdat;
    logic                   o_ext_mem_rdy;
    logic                   o_ext_mem_busy;
    logic                   o_ext_mem_err;

    modport slave (
        input  i_mem_ext_rden, i_mem_ext_wren, i_mem_ext_mask, i_mem_ext_burst,
               i_mem_ext_paddr, i_mem_ext_wdat, i_mem_ext_burst_start,
               i_mem_ext_burst_end, i_mem_ext_burst_vld,
        output o_ext_mem_rdat, o_ext_mem_rdy, o_ext_mem_busy, o_ext_mem_err
    );

    modport master (
        output i_mem_ext_rden, i_mem_ext_wren, i_mem_ext_mask, i_mem_ext_burst,
               i_mem_ext_paddr, i_mem_ext_wdat, i_mem_ext_burst_start,
               i_mem_ext_burst_end, i_mem_ext_burst_vld,
        input  o_ext_mem_rdat, o_ext_mem_rdy, o_ext_mem_busy, o_ext_mem_err
    );
endinterface

// File: rtl/ext_mem_resp_module.sv
// External-memory responder: services mem_ext read/write bursts from a 128-bit word array
// with programmable read latency and a one-cycle write-completion strobe.
module ext_mem_resp_module #(
    parameter int PADDR_WIDTH = 34,
    parameter int AW          = 10,
    parameter int RD_LAT      = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ext_mem_resp_module_if.slave   mem_if
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_ACK} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [3:0]      n_q, n_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      lat_q, lat_d;
    logic            err_q, err_d;
    logic [127:0]    rdat_q;
    logic [127:0]    mem [2**AW];

    logic [AW-1:0]   req_idx;
    logic [3:0]      req_n;
    logic            req_ill;
    logic            we;
    logic [AW-1:0]   widx;
    logic [AW-1:0]   ridx;
    logic            unused_paddr;

    assign unused_paddr = ^{mem_if.i_mem_ext_paddr[3:0],
                            mem_if.i_mem_ext_paddr[PADDR_WIDTH-1:AW+4]};

    always_comb begin
        req_idx = mem_if.i_mem_ext_paddr[AW+3:4];
        req_ill = 1'b0;
        case (mem_if.i_mem_ext_burst)
            3'd0:    req_n = 4'd1;
            3'd1:    req_n = 4'd2;
            3'd2:    req_n = 4'd4;
            3'd3:    req_n = 4'd8;
            default: begin
                req_n   = 4'd1;
                req_ill = 1'b1;
            end
        endcase
    end

    // Next state plus datapath updates; write beats land on the edge that accepts them.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        err_d   = 1'b0;
        we      = 1'b0;
        widx    = base_q + AW'(cnt_q);
        case (state_q)
            IDLE: begin
                if (mem_if.i_mem_ext_rden) begin
                    base_d  = req_idx;
                    n_d     = req_n;
                    cnt_d   = 4'd0;
                    lat_d   = 4'(RD_LAT - 1);
                    err_d   = req_ill | mem_if.i_mem_ext_wren;
                    state_d = (RD_LAT == 1) ? RD_BEAT : RD_WAIT;
                end else if (mem_if.i_mem_ext_wren && mem_if.i_mem_ext_burst_vld &&
                             mem_if.i_mem_ext_burst_start) begin
                    base_d = req_idx;
                    n_d    = req_n;
                    cnt_d  = 4'd1;
                    we     = 1'b1;
                    widx   = req_idx;
                    err_d  = req_ill;
                    if (mem_if.i_mem_ext_burst_end) begin
                        state_d = WR_ACK;
                        if (req_n != 4'd1) err_d = 1'b1;
                    end else if (req_n == 4'd1) begin
                        state_d = WR_ACK;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WR_BEAT;
                    end
                end
            end
            RD_WAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q == 4'd1) state_d = RD_BEAT;
            end
            RD_BEAT: begin
                if (cnt_q == n_q - 4'd1) state_d = IDLE;
                else                     cnt_d   = cnt_q + 4'd1;
            end
            WR_BEAT: begin
                if (mem_if.i_mem_ext_burst_vld) begin
                    we    = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                    err_d = mem_if.i_mem_ext_burst_start;
                    if (mem_if.i_mem_ext_burst_end) begin
                        state_d = WR_ACK;
                        if (cnt_q + 4'd1 != n_q) err_d = 1'b1;
                    end else if (cnt_q + 4'd1 == n_q) begin
                        state_d = WR_ACK;
                        err_d   = 1'b1;
                    end
                end
            end
            WR_ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ridx = base_d + AW'(cnt_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
            if (state_d == RD_BEAT) rdat_q <= mem[ridx];
        end
    end

    // Array is not reset; writes are simply suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            for (int b = 0; b < 16; b++) begin
                if (mem_if.i_mem_ext_mask[b]) mem[widx][8*b +: 8] <= mem_if.i_mem_ext_wdat[8*b +: 8];
            end
        end
    end

    always_comb begin
        mem_if.o_ext_mem_rdy  = (state_q == RD_BEAT) || (state_q == WR_ACK);
        mem_if.o_ext_mem_busy = (state_q != IDLE);
        mem_if.o_ext_mem_err  = err_q;
        mem_if.o_ext_mem_rdat = rdat_q;
    end
endmodule

// File: tb/tb_ext_mem_resp_module.sv
// Directed bench for ext_mem_resp_module: masked single writes/reads from a table,
// then hand sequences for bursts, stalls, wrap, protocol errors and reset mid-read.
module tb_ext_mem_resp_module;
    localparam int RD_LAT = 3;
    localparam logic [127:0] BG = {16{8'hAA}};

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [127:0] expw [8];

    always #5 clk = ~clk;

    ext_mem_resp_module_if #(.PADDR_WIDTH(34)) bus ();

    ext_mem_resp_module #(.PADDR_WIDTH(34), .AW(10), .RD_LAT(RD_LAT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mem_if (bus)
    );

    typedef struct {
        logic [33:0]  paddr;
        logic [15:0]  mask;
        logic [127:0] wdat;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.i_mem_ext_rden        = 1'b0;
        bus.i_mem_ext_wren        = 1'b0;
        bus.i_mem_ext_mask        = '0;
        bus.i_mem_ext_burst       = '0;
        bus.i_mem_ext_paddr       = '0;
        bus.i_mem_ext_wdat        = '0;
        bus.i_mem_ext_burst_start = 1'b0;
        bus.i_mem_ext_burst_end   = 1'b0;
        bus.i_mem_ext_burst_vld   = 1'b0;
    endtask

    task automatic write1(input logic [33:0] a, input logic [15:0] m, input logic [127:0] d);
        bus.i_mem_ext_wren        = 1'b1;
        bus.i_mem_ext_burst_vld   = 1'b1;
        bus.i_mem_ext_burst_start = 1'b1;
        bus.i_mem_ext_burst_end   = 1'b1;
        bus.i_mem_ext_burst       = 3'd0;
        bus.i_mem_ext_paddr       = a;
        bus.i_mem_ext_mask        = m;
        bus.i_mem_ext_wdat        = d;
        tick();
        idle_bus();
        chk1("wr1_ack", bus.o_ext_mem_rdy, 1'b1);
        chk1("wr1_err", bus.o_ext_mem_err, 1'b0);
        tick();
        chk1("wr1_idle", bus.o_ext_mem_busy, 1'b0);
    endtask

    // Read burst checked against expw[0..n-1]; optionally also raises a write request.
    task automatic rd_check(input string nm, input logic [33:0] a, input logic [2:0] b,
                            input int n, input logic exp_err, input logic wr_too);
        bus.i_mem_ext_rden        = 1'b1;
        bus.i_mem_ext_wren        = wr_too;
        bus.i_mem_ext_burst_vld   = wr_too;
        bus.i_mem_ext_burst_start = wr_too;
        bus.i_mem_ext_burst_end   = wr_too;
        bus.i_mem_ext_mask        = 16'hFFFF;
        bus.i_mem_ext_wdat        = {128{1'b1}};
        bus.i_mem_ext_paddr       = a;
        bus.i_mem_ext_burst       = b;
        tick();
        idle_bus();
        chk1({nm, "_err"}, bus.o_ext_mem_err, exp_err);
        for (int k = 1; k < RD_LAT; k++) begin
            chk1({nm, "_lat_rdy"}, bus.o_ext_mem_rdy, 1'b0);
            tick();
        end
        for (int i = 0; i < n; i++) begin
            chk1({nm, "_beat_rdy"}, bus.o_ext_mem_rdy, 1'b1);
            chk({nm, "_beat_dat"}, bus.o_ext_mem_rdat, expw[i]);
            tick();
        end
        chk1({nm, "_end_rdy"}, bus.o_ext_mem_rdy, 1'b0);
        chk1({nm, "_end_busy"}, bus.o_ext_mem_busy, 1'b0);
    endtask

    initial begin : main
        logic [127:0] wa, wb, wc, wd, wy;
        int errs;
        tbl[0] = '{34'h40,   16'hFFFF, 128'h0123456789ABCDEF_FEDCBA9876543210,
                              128'h0123456789ABCDEF_FEDCBA9876543210};
        tbl[1] = '{34'h85,   16'h000F, 128'h11111111_22222222_33333333_44444444,
                              128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_44444444};
        tbl[2] = '{34'h3FF0, 16'h8001, 128'h55000000_00000000_00000000_00000066,
                              128'h55AAAAAA_AAAAAAAA_AAAAAAAA_AAAAAA66};
        tbl[3] = '{34'h4010, 16'h0000, 128'h99999999_99999999_99999999_99999999, BG};
        tbl[4] = '{34'h20,   16'hF0F0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                              128'hFFFFFFFF_AAAAAAAA_FFFFFFFF_AAAAAAAA};

        idle_bus();
        rst_n = 1'b0;
        tick();
        tick();
        chk1("rst_rdy", bus.o_ext_mem_rdy, 1'b0);
        chk1("rst_busy", bus.o_ext_mem_busy, 1'b0);
        chk1("rst_err", bus.o_ext_mem_err, 1'b0);
        chk("rst_rdat", bus.o_ext_mem_rdat, 128'h0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            write1(tbl[v].paddr, 16'hFFFF, BG);
            write1(tbl[v].paddr, tbl[v].mask, tbl[v].wdat);
            expw[0] = tbl[v].exp;
            rd_check("vec", tbl[v].paddr, 3'd0, 1, 1'b0, 1'b0);
        end

        // 4-beat line refill from words 8..11
        wa = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
        wb = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
        wc = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
        wd = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
        write1(34'h80, 16'hFFFF, wa);
        write1(34'h90, 16'hFFFF, wb);
        write1(34'hA0, 16'hFFFF, wc);
        write1(34'hB0, 16'hFFFF, wd);
        expw[0] = wa; expw[1] = wb; expw[2] = wc; expw[3] = wd;
        rd_check("rd4", 34'h80, 3'd2, 4, 1'b0, 1'b0);

        // 4-beat write with a stall and a partial mask on beat 2
        for (int i = 0; i < 4; i++) write1(34'h200 + 34'(16 * i), 16'hFFFF, BG);
        errs = 0;
        bus.i_mem_ext_wren = 1'b1; bus.i_mem_ext_burst_vld = 1'b1; bus.i_mem_ext_burst_start = 1'b1;
        bus.i_mem_ext_burst = 3'd2; bus.i_mem_ext_paddr = 34'h200;
        bus.i_mem_ext_mask = 16'hFFFF; bus.i_mem_ext_wdat = wd;
        tick();
        errs += int'(bus.o_ext_mem_err);
        chk1("wr4_busy", bus.o_ext_mem_busy, 1'b1);
        bus.i_mem_ext_burst_vld = 1'b0; bus.i_mem_ext_burst_start = 1'b0;
        tick();
        errs += int'(bus.o_ext_mem_err);
        bus.i_mem_ext_burst_vld = 1'b1; bus.i_mem_ext_wdat = wc;
        tick();
        errs += int'(bus.o_ext_mem_err);
        bus.i_mem_ext_mask = 16'h000F; bus.i_mem_ext_wdat = 128'h12121212_34343434_56565656_78787878;
        tick();
        errs += int'(bus.o_ext_mem_err);
        chk1("wr4_no_early_ack", bus.o_ext_mem_rdy, 1'b0);
        bus.i_mem_ext_mask = 16'hFFFF; bus.i_mem_ext_burst_end = 1'b1; bus.i_mem_ext_wdat = wb;
        tick();
        idle_bus();
        errs += int'(bus.o_ext_mem_err);
        chk1("wr4_ack", bus.o_ext_mem_rdy, 1'b1);
        chk("wr4_err_count", 128'(errs), 128'h0);
        tick();
        chk1("wr4_ack_len", bus.o_ext_mem_rdy, 1'b0);
        chk1("wr4_idle", bus.o_ext_mem_busy, 1'b0);
        expw[0] = wd; expw[1] = wc;
        expw[2] = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_78787878; expw[3] = wb;
        rd_check("wr4_rd", 34'h200, 3'd2, 4, 1'b0, 1'b0);

        // Wrap from word 1023 to word 0
        wy = 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C;
        write1(34'h0, 16'hFFFF, wy);
        expw[0] = tbl[2].exp; expw[1] = wy;
        rd_check("wrap", 34'h3FF0, 3'd1, 2, 1'b0, 1'b0);

        // Illegal burst code behaves as a single beat with an error pulse
        expw[0] = tbl[0].exp;
        rd_check("ill", 34'h40, 3'd5, 1, 1'b1, 1'b0);

        // Read and write together: read wins, write must not land
        rd_check("rdwr", 34'h40, 3'd0, 1, 1'b1, 1'b1);
        rd_check("rdwr_after", 34'h40, 3'd0, 1, 1'b0, 1'b0);

        // Early burst_end on beat 2 of a 4-beat write
        bus.i_mem_ext_wren = 1'b1; bus.i_mem_ext_burst_vld = 1'b1; bus.i_mem_ext_burst_start = 1'b1;
        bus.i_mem_ext_burst = 3'd2; bus.i_mem_ext_paddr = 34'h300;
        bus.i_mem_ext_mask = 16'hFFFF; bus.i_mem_ext_wdat = wa;
        tick();
        chk1("early_err_b0", bus.o_ext_mem_err, 1'b0);
        bus.i_mem_ext_burst_start = 1'b0; bus.i_mem_ext_burst_end = 1'b1; bus.i_mem_ext_wdat = wb;
        tick();
        idle_bus();
        chk1("early_ack", bus.o_ext_mem_rdy, 1'b1);
        chk1("early_err", bus.o_ext_mem_err, 1'b1);
        tick();
        chk1("early_idle", bus.o_ext_mem_busy, 1'b0);
        chk1("early_err_pulse", bus.o_ext_mem_err, 1'b0);

        // Reset during beat 1 of a 4-beat read
        bus.i_mem_ext_rden = 1'b1; bus.i_mem_ext_burst = 3'd2; bus.i_mem_ext_paddr = 34'h80;
        tick();
        idle_bus();
        tick();
        tick();
        chk("rst_mid_b0", bus.o_ext_mem_rdat, wa);
        tick();
        chk1("rst_mid_b1_rdy", bus.o_ext_mem_rdy, 1'b1);
        chk("rst_mid_b1", bus.o_ext_mem_rdat, wb);
        rst_n = 1'b0;
        tick();
        chk1("rst_mid_rdy", bus.o_ext_mem_rdy, 1'b0);
        chk1("rst_mid_busy", bus.o_ext_mem_busy, 1'b0);
        chk("rst_mid_rdat", bus.o_ext_mem_rdat, 128'h0);
        rst_n = 1'b1;
        tick();
        expw[0] = wa;
        rd_check("post_rst", 34'h80, 3'd0, 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ext_mem_resp_module.md
Name: ext_mem_resp_module

Overview:
- External-memory responder: the slave end of the `mem_ext` burst interface that the MMU page walker and the cache refill paths drive.
- Accepts single- or multi-beat 128-bit read and write bursts and services them from an internal 128-bit-word array.
- Returns read beats with a programmable latency and acknowledges writes on the shared `rdy` strobe.
- Serves as the system-level memory model for the core, and as the reference slave when verifying the MMU/PTW memory path.

Parameters:
- PADDR_WIDTH, 34, physical address width (matches the `mem_ext` paddr bus).
- AW, 10, log2 of array depth in 128-bit words.
- RD_LAT, 3, cycles from read accept to first read beat; legal range 1..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- i_mem_ext_rden  input  1  read request
- i_mem_ext_wren  input  1  write request
- i_mem_ext_mask  input  16  byte enables for the write beat; bit k enables byte k
- i_mem_ext_burst  input  3  burst length code: 0→1 beat, 1→2, 2→4, 3→8; codes 4..7 illegal
- i_mem_ext_paddr  input  PADDR_WIDTH  burst start byte address
- i_mem_ext_wdat  input  128  write beat data
- i_mem_ext_burst_start  input  1  marks the first write beat
- i_mem_ext_burst_end  input  1  marks the last write beat
- i_mem_ext_burst_vld  input  1  write beat valid
- o_ext_mem_rdat  output  128  read beat data
- o_ext_mem_rdy  output  1  read beat valid, or write-completion pulse
- o_ext_mem_busy  output  1  high whenever the state is not IDLE
- o_ext_mem_err  output  1  one-cycle pulse on a protocol error

Behaviour:
- Reset:
  - FSM returns to IDLE.
  - o_ext_mem_rdy = 0, o_ext_mem_busy = 0, o_ext_mem_err = 0, o_ext_mem_rdat = 0.
  - Beat and latency counters are cleared.
  - Array contents are not reset.
  - Reset asserted mid-burst aborts the burst on the next edge; remaining beats are dropped and no ack is issued.
- Word index: paddr[AW+3:4]; paddr[3:0] is ignored (16-byte aligned). Each beat increments the index by 1, wrapping modulo 2^AW.
- Beat count N = 1 << burst. An illegal burst code gives N = 1 and a one-cycle o_ext_mem_err pulse at accept.
- FSM states: IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_ACK.
- IDLE:
  - rden=1 → accept the read. Latch index and N, load the latency counter with RD_LAT-1, go to RD_WAIT. If RD_LAT=1, go directly to RD_BEAT.
  - Else if wren & burst_vld & burst_start → accept the write and write beat 0 this cycle under the mask.
    - If burst_end is also high, go to WR_ACK. This is legal only when N=1; otherwise err pulses.
    - Otherwise go to WR_BEAT with the beat counter = 1.
  - wren without burst_vld & burst_start is ignored.
  - rden and wren together: read wins; the write is ignored and err pulses.
- RD_WAIT: decrement the counter; at 0, go to RD_BEAT.
- Read timing:
  - Accept at cycle T → first rdy=1 at cycle T+RD_LAT.
  - rdy stays high for exactly N consecutive cycles, rdat = array[index+i] on beat i.
  - After the last beat, go to IDLE; rdy=0 on the following cycle.
  - No back-pressure.
  - rdat holds its last value when rdy=0.
- WR_BEAT:
  - Each cycle with burst_vld=1 writes wdat under the mask to index+count and increments count. burst_vld=0 cycles are stalls.
  - burst_start=1 inside WR_BEAT → err pulse; the beat is still written.
  - On a beat with burst_end=1, go to WR_ACK. If count+1 ≠ N, err pulses.
  - If count reaches N without burst_end, the burst closes, err pulses, and the FSM goes to WR_ACK.
- WR_ACK: rdy=1 for one cycle, then IDLE. A new request is acceptable in the cycle after WR_ACK.
- Requests arriving while busy are ignored; no queueing. Masters must wait for busy=0.
- Array access:
  - Single write port: 16 byte lanes, read-modify-write free.
  - Read is combinational from the registered index; rdat is registered.
  - A write to index X followed by a read of X returns the new data.

Test Plan:
- Single write then read: wren, burst=0, paddr=0x40, mask=0xFFFF, wdat=0x0123_..._CDEF → rdy at T+1. Then rden, paddr=0x40 → rdy exactly at T'+3 with the same data, rdy=1 for 1 cycle.
- 4-beat read (line refill): preload words 8..11 = A,B,C,D; rden, burst=2, paddr=0x80 → rdy high for cycles T+3..T+6, rdat A,B,C,D, busy drops at T+7.
- 4-beat write with stall: burst_vld pattern 1,0,1,1,1 with burst_end on the 4th valid beat → four words written, one ack pulse, err=0. A partial mask of 0x000F on beat 2 changes only bytes 0..3 of that word.
- Wrap and illegal code:
  - burst=1 at index 2^AW-1 → beats read word 1023 then word 0.
  - burst=5 → one beat and an err pulse at accept.
- Protocol errors:
  - rden and wren together → read served, err=1 for one cycle.
  - burst_end on beat 2 of a burst=2 write → WR_ACK after 2 beats, err=1.
- Reset mid-read: assert rst_n=0 during RD_BEAT beat 1 → next cycle rdy=0, busy=0, rdat=0, and a new request is accepted normally after release.
